// File: rtl/icache_assoc_if.sv
// Fetch-side and refill-side signal bundle for icache_assoc.
// The cache connects through the slave modport; the fetch unit / memory side uses master.
interface icache_assoc_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic [ADDR_W-1:0] addr_in;
  logic              flush;
  logic [DATA_W-1:0] data_out;
  logic              iCache_stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_dataOut;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  addr_in, flush, mem_ack, mem_dataOut,
    output data_out, iCache_stall, mem_req, mem_addr, hit_count, miss_count
  );

  modport master (
    output addr_in, flush, mem_ack, mem_dataOut,
    input  data_out, iCache_stall, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache: 0-cycle hits, in-order line refill over a
// req/ack memory handshake, fence.i flush, saturating hit/miss counters.
module icache_assoc #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CNT_W      = 32
) (
  input logic           clock,
  input logic           reset,
  icache_assoc_if.slave bus
);
  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned BeatW = (OFF_W > 0) ? OFF_W : 1;
  localparam int unsigned WayW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {StIdle, StRefill} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] dataMem [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0]  tagMem  [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];

  logic [ADDR_W-1:0] base_q;
  logic [BeatW-1:0]  beat_q;
  logic [WayW-1:0]   victim_q;
  logic              flushPending_q;
  logic [CNT_W-1:0]  hitCnt_q, missCnt_q;

  logic [BeatW-1:0]  off;
  logic [IDX_W-1:0]  idx, refIdx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [WayW-1:0]   hitWay, victim, rrSel;
  logic              lookupHit, lookupMiss, ackd, lastBeat, fillDone;

  assign off    = (LINE_WORDS > 1) ? bus.addr_in[BeatW-1:0] : '0;
  assign idx    = bus.addr_in[OFF_W +: IDX_W];
  assign tag    = bus.addr_in[OFF_W+IDX_W +: TAG_W];
  assign refIdx = base_q[OFF_W +: IDX_W];

  always_comb begin
    hit    = 1'b0;
    hitWay = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[idx][w] && (tagMem[w][idx] == tag)) begin
        hit    = 1'b1;
        hitWay = WayW'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise fall back to the round-robin pointer.
  always_comb begin
    victim = rrSel;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim = WayW'(w);
    end
  end

  assign lookupHit  = (state_q == StIdle) && hit;
  assign lookupMiss = (state_q == StIdle) && !hit;
  assign ackd       = (state_q == StRefill) && bus.mem_ack;
  assign lastBeat   = (beat_q == BeatW'(LINE_WORDS - 1));
  assign fillDone   = ackd && lastBeat;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!hit) state_d = StRefill;
      StRefill: if (fillDone) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are held quiet while reset is asserted even though every line reads invalid.
  assign bus.iCache_stall = reset && ((state_q == StRefill) || !hit);
  assign bus.data_out     = (reset && lookupHit) ? dataMem[hitWay][idx][off] : '0;
  assign bus.mem_req      = (state_q == StRefill);
  assign bus.mem_addr     = bus.mem_req ? base_q + ADDR_W'(beat_q) : '0;
  assign bus.hit_count    = hitCnt_q;
  assign bus.miss_count   = missCnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      base_q         <= '0;
      beat_q         <= '0;
      victim_q       <= '0;
      flushPending_q <= 1'b0;
      hitCnt_q       <= '0;
      missCnt_q      <= '0;
      valid_q        <= '{default: '0};
    end else begin
      state_q <= state_d;
      if (lookupMiss) begin
        base_q   <= bus.addr_in & ~ADDR_W'(LINE_WORDS - 1);
        beat_q   <= '0;
        victim_q <= victim;
        if (missCnt_q != {CNT_W{1'b1}}) missCnt_q <= missCnt_q + 1'b1;
      end
      if (ackd) beat_q <= beat_q + 1'b1;
      if (lookupHit && (hitCnt_q != {CNT_W{1'b1}})) hitCnt_q <= hitCnt_q + 1'b1;

      if (state_q == StRefill) begin
        if (fillDone)       flushPending_q <= 1'b0;
        else if (bus.flush) flushPending_q <= 1'b1;
      end

      if ((state_q == StIdle) && bus.flush) begin
        valid_q <= '{default: '0};
      end else if (fillDone) begin
        if (flushPending_q || bus.flush) valid_q <= '{default: '0};
        else                             valid_q[refIdx][victim_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ackd)     dataMem[victim_q][refIdx][beat_q] <= bus.mem_dataOut;
    if (fillDone) tagMem[victim_q][refIdx] <= base_q[OFF_W+IDX_W +: TAG_W];
  end

  if (WAYS > 1) begin : gen_rr
    logic [WayW-1:0] rrPtr_q [SETS];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rrPtr_q <= '{default: '0};
      end else if (fillDone) begin
        rrPtr_q[refIdx] <= rrPtr_q[refIdx] + 1'b1;
      end
    end

    assign rrSel = rrPtr_q[idx];
  end else begin : gen_no_rr
    assign rrSel = '0;
  end
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: fixed-latency memory responder plus one task per scenario.
module tb_icache_assoc;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   waitCnt = 0;
  logic [ADDR_W-1:0] ackAddrs[$];

  always #5 clock = ~clock;

  icache_assoc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  icache_assoc #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(2), .SETS(16), .LINE_WORDS(4), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a};
  endfunction

  // Memory: acks on the third falling edge that sees mem_req, one pulse per word.
  initial begin
    bus.mem_ack     = 1'b0;
    bus.mem_dataOut = '0;
    forever begin
      @(negedge clock);
      bus.mem_ack = 1'b0;
      if (reset && bus.mem_req) begin
        if (waitCnt == 2) begin
          bus.mem_ack     = 1'b1;
          bus.mem_dataOut = memWord(bus.mem_addr);
          ackAddrs.push_back(bus.mem_addr);
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  task automatic waitIdle(output int cyc);
    cyc = 0;
    do begin
      @(negedge clock); #1; cyc++;
    end while (bus.iCache_stall && cyc < 200);
    if (bus.iCache_stall) begin
      total++; bad++;
      $display("FAIL wait_idle: stall still %b after %0d cycles, want 0", bus.iCache_stall, cyc);
    end
  endtask

  task automatic waitAcks(input int n);
    int cyc = 0;
    while (ackAddrs.size() < n && cyc < 200) begin
      @(negedge clock); #1; cyc++;
    end
    if (ackAddrs.size() < n) begin
      total++; bad++;
      $display("FAIL wait_acks: got %0d acks, want %0d", ackAddrs.size(), n);
    end
  endtask

  task automatic test_reset();
    bus.addr_in = 30'h10;
    bus.flush   = 1'b0;
    #3 reset = 1'b0;
    @(negedge clock); #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.mem_req); end
    total++; if (bus.mem_addr !== 30'h0) begin bad++; $display("FAIL rst_maddr: got %h want 0", bus.mem_addr); end
    total++; if (bus.iCache_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", bus.iCache_stall); end
    total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.data_out); end
    total++; if (bus.hit_count !== 32'd0) begin bad++; $display("FAIL rst_hit: got %0d want 0", bus.hit_count); end
    total++; if (bus.miss_count !== 32'd0) begin bad++; $display("FAIL rst_miss: got %0d want 0", bus.miss_count); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (bus.iCache_stall !== 1'b1) begin bad++; $display("FAIL rel_stall: got %b want 1", bus.iCache_stall); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rel_req: got %b want 0", bus.mem_req); end
  endtask

  task automatic test_cold_miss();
    int cyc;
    waitIdle(cyc);
    total++; if (cyc !== 13) begin bad++; $display("FAIL cold_latency: got %0d cycles want 13", cyc); end
    total++; if (ackAddrs.size() !== 4) begin bad++; $display("FAIL cold_beats: got %0d want 4", ackAddrs.size()); end
    for (int i = 0; i < 4 && i < ackAddrs.size(); i++) begin
      total++;
      if (ackAddrs[i] !== 30'h10 + 30'(i)) begin
        bad++; $display("FAIL cold_addr%0d: got %h want %h", i, ackAddrs[i], 30'h10 + 30'(i));
      end
    end
    total++; if (bus.data_out !== 32'hC0DE_0010) begin bad++; $display("FAIL cold_data: got %h want c0de0010", bus.data_out); end
    total++; if (bus.miss_count !== 32'd1) begin bad++; $display("FAIL cold_miss: got %0d want 1", bus.miss_count); end
    total++; if (bus.hit_count !== 32'd0) begin bad++; $display("FAIL cold_hit0: got %0d want 0", bus.hit_count); end
    @(negedge clock); #1;
    total++; if (bus.hit_count !== 32'd1) begin bad++; $display("FAIL cold_relookup: got %0d want 1", bus.hit_count); end
  endtask

  task automatic test_sequential();
    logic [ADDR_W-1:0] a;
    for (int i = 1; i < 4; i++) begin
      a = 30'h10 + 30'(i);
      bus.addr_in = a;
      #1;
      total++; if (bus.iCache_stall !== 1'b0) begin bad++; $display("FAIL seq_stall %h: got %b want 0", a, bus.iCache_stall); end
      total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL seq_req %h: got %b want 0", a, bus.mem_req); end
      total++; if (bus.data_out !== memWord(a)) begin bad++; $display("FAIL seq_data %h: got %h want %h", a, bus.data_out, memWord(a)); end
      @(negedge clock); #1;
    end
    total++; if (bus.hit_count !== 32'd4) begin bad++; $display("FAIL seq_hits: got %0d want 4", bus.hit_count); end
    total++; if (ackAddrs.size() !== 4) begin bad++; $display("FAIL seq_noreq: got %0d acks want 4", ackAddrs.size()); end
  endtask

  task automatic test_eviction();
    logic [ADDR_W-1:0] seq [4] = '{30'h000, 30'h040, 30'h080, 30'h000};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      bus.addr_in = seq[i];
      #1;
      total++; if (bus.iCache_stall !== 1'b1) begin bad++; $display("FAIL evict_miss%0d: got %b want 1", i, bus.iCache_stall); end
      waitIdle(cyc);
      total++; if (bus.data_out !== memWord(seq[i])) begin bad++; $display("FAIL evict_data%0d: got %h want %h", i, bus.data_out, memWord(seq[i])); end
    end
    total++; if (bus.miss_count !== 32'd5) begin bad++; $display("FAIL evict_misses: got %0d want 5", bus.miss_count); end
    bus.addr_in = 30'h081;
    #1;
    total++; if (bus.iCache_stall !== 1'b0) begin bad++; $display("FAIL evict_keep080: got %b want 0", bus.iCache_stall); end
    total++; if (bus.data_out !== 32'hC0DE_0081) begin bad++; $display("FAIL evict_data081: got %h want c0de0081", bus.data_out); end
    bus.addr_in = 30'h040;
    #1;
    total++; if (bus.iCache_stall !== 1'b1) begin bad++; $display("FAIL evict_gone040: got %b want 1", bus.iCache_stall); end
    waitIdle(cyc);
    bus.addr_in = 30'h002;
    #1;
    total++; if (bus.iCache_stall !== 1'b0) begin bad++; $display("FAIL evict_keep000: got %b want 0", bus.iCache_stall); end
    total++; if (bus.data_out !== 32'hC0DE_0002) begin bad++; $display("FAIL evict_data002: got %h want c0de0002", bus.data_out); end
    bus.addr_in = 30'h080;
    #1;
    total++; if (bus.iCache_stall !== 1'b1) begin bad++; $display("FAIL evict_gone080: got %b want 1", bus.iCache_stall); end
    waitIdle(cyc);
    total++; if (bus.miss_count !== 32'd7) begin bad++; $display("FAIL evict_misses2: got %0d want 7", bus.miss_count); end
  endtask

  task automatic test_flush_idle();
    int cyc;
    bus.addr_in = 30'h011;
    bus.flush   = 1'b1;
    #1;
    total++; if (bus.iCache_stall !== 1'b0) begin bad++; $display("FAIL fli_prehit: got %b want 0", bus.iCache_stall); end
    total++; if (bus.data_out !== 32'hC0DE_0011) begin bad++; $display("FAIL fli_data: got %h want c0de0011", bus.data_out); end
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    total++; if (bus.iCache_stall !== 1'b1) begin bad++; $display("FAIL fli_cleared: got %b want 1", bus.iCache_stall); end
    waitIdle(cyc);
    total++; if (bus.miss_count !== 32'd8) begin bad++; $display("FAIL fli_misses: got %0d want 8", bus.miss_count); end
  endtask

  task automatic test_flush_refill();
    int cyc;
    bus.addr_in = 30'h020;
    ackAddrs.delete();
    #1;
    total++; if (bus.iCache_stall !== 1'b1) begin bad++; $display("FAIL flr_miss: got %b want 1", bus.iCache_stall); end
    @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    waitAcks(4);
    for (int i = 0; i < 4 && i < ackAddrs.size(); i++) begin
      total++;
      if (ackAddrs[i] !== 30'h20 + 30'(i)) begin
        bad++; $display("FAIL flr_addr%0d: got %h want %h", i, ackAddrs[i], 30'h20 + 30'(i));
      end
    end
    @(negedge clock); #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL flr_reqdrop: got %b want 0", bus.mem_req); end
    total++; if (bus.iCache_stall !== 1'b1) begin bad++; $display("FAIL flr_notvalid: got %b want 1", bus.iCache_stall); end
    @(negedge clock); #1;
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL flr_rereq: got %b want 1", bus.mem_req); end
    total++; if (bus.mem_addr !== 30'h20) begin bad++; $display("FAIL flr_restart: got %h want 20", bus.mem_addr); end
    waitIdle(cyc);
    total++; if (bus.data_out !== 32'hC0DE_0020) begin bad++; $display("FAIL flr_data: got %h want c0de0020", bus.data_out); end
    total++; if (bus.miss_count !== 32'd10) begin bad++; $display("FAIL flr_misses: got %0d want 10", bus.miss_count); end
    bus.addr_in = 30'h011;
    #1;
    total++; if (bus.iCache_stall !== 1'b1) begin bad++; $display("FAIL flr_allflushed: got %b want 1", bus.iCache_stall); end
    waitIdle(cyc);
  endtask

  task automatic test_reset_mid_refill();
    int cyc;
    bus.addr_in = 30'h030;
    ackAddrs.delete();
    waitAcks(2);
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rmr_req: got %b want 0", bus.mem_req); end
    total++; if (bus.miss_count !== 32'd0) begin bad++; $display("FAIL rmr_miss0: got %0d want 0", bus.miss_count); end
    total++; if (bus.hit_count !== 32'd0) begin bad++; $display("FAIL rmr_hit0: got %0d want 0", bus.hit_count); end
    @(negedge clock);
    reset = 1'b1;
    ackAddrs.delete();
    #1;
    total++; if (bus.iCache_stall !== 1'b1) begin bad++; $display("FAIL rmr_invalid: got %b want 1", bus.iCache_stall); end
    waitIdle(cyc);
    total++; if (cyc !== 13) begin bad++; $display("FAIL rmr_latency: got %0d cycles want 13", cyc); end
    total++; if (ackAddrs.size() !== 4) begin bad++; $display("FAIL rmr_beats: got %0d want 4", ackAddrs.size()); end
    if (ackAddrs.size() > 0) begin
      total++; if (ackAddrs[0] !== 30'h30) begin bad++; $display("FAIL rmr_word0: got %h want 30", ackAddrs[0]); end
    end
    total++; if (bus.miss_count !== 32'd1) begin bad++; $display("FAIL rmr_miss1: got %0d want 1", bus.miss_count); end
    @(negedge clock); #1;
    total++; if (bus.hit_count !== 32'd1) begin bad++; $display("FAIL rmr_hit1: got %0d want 1", bus.hit_count); end
    total++; if (bus.data_out !== 32'hC0DE_0030) begin bad++; $display("FAIL rmr_data: got %h want c0de0030", bus.data_out); end
  endtask

  task automatic test_saturate();
    force dut.hitCnt_q = CntMax;
    #1;
    release dut.hitCnt_q;
    total++; if (bus.iCache_stall !== 1'b0) begin bad++; $display("FAIL sat_hit: got %b want 0", bus.iCache_stall); end
    @(negedge clock); #1;
    total++; if (bus.hit_count !== CntMax) begin bad++; $display("FAIL sat_hold: got %h want %h", bus.hit_count, CntMax); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_sequential();
    test_eviction();
    test_flush_idle();
    test_flush_refill();
    test_reset_mid_refill();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
